// File: rtl/mole_generator_pkg.sv
// Shared types and constants for the mole generator: widths, FSM states,
// LFSR constants and the score-to-dwell conversion.
package mole_generator_pkg;

  localparam int POS_W     = 3;
  localparam int SCORE_W   = 8;
  localparam int CNT_W     = 28;
  localparam int DW_CALC_W = 36;

  // Galois form of x^16+x^14+x^13+x^11, shifting right
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_HIDE = 2'd0,
    ST_SHOW = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Dwell shrinks with score; wide unsigned math so high scores can't wrap,
  // and anything that would go below the floor is clamped to it.
  function automatic logic [CNT_W-1:0] calc_dwell(
    input logic [SCORE_W-1:0] score,
    input int unsigned        dinit,
    input int unsigned        dmin,
    input int unsigned        dstep
  );
    logic [DW_CALC_W-1:0] w_red;
    logic [DW_CALC_W-1:0] w_init;
    logic [DW_CALC_W-1:0] w_min;
    w_red  = DW_CALC_W'(score) * DW_CALC_W'(dstep);
    w_init = DW_CALC_W'(dinit);
    w_min  = DW_CALC_W'(dmin);
    if (w_red >= w_init || (w_init - w_red) < w_min)
      calc_dwell = CNT_W'(dmin);
    else
      calc_dwell = CNT_W'(w_init - w_red);
  endfunction

endpackage

// File: rtl/mole_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR; loads the seed on reset and steps every cycle.
module lfsr16
  import mole_generator_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= seed;
    else        r_q <= (r_q >> 1) ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
  end

  assign q = r_q;

endmodule

// File: rtl/mole_generator.sv
// Picks the active hole, times the gap and dwell of each mole, and hides it on
// a hit, on dwell expiry, or when the game is over.
module mole_generator
  import mole_generator_pkg::*;
#(
  parameter int unsigned GAP_TICKS  = 5000,
  parameter int unsigned DWELL_INIT = 10000,
  parameter int unsigned DWELL_MIN  = 2000,
  parameter int unsigned DWELL_STEP = 200,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_restart_game,
  input  logic               i_game_over,
  input  logic               i_guess_correct,
  input  logic [SCORE_W-1:0] i_score,
  output logic [POS_W-1:0]   mole_pos,
  output logic               mole_change,
  output logic               mole_visible
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  state_e             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_gap_cnt, w_gap_nx;
  logic [CNT_W-1:0]   r_dwell_cnt, w_dwell_cnt_nx;
  logic [CNT_W-1:0]   r_dwell, w_dwell_nx;
  logic [POS_W-1:0]   r_pos, w_pos_nx;
  logic               r_change, w_change_nx;
  logic [15:0]        w_seed;
  logic [15:0]        w_lfsr;
  logic [POS_W-1:0]   w_lfsr_pos;
  logic [POS_W-1:0]   w_cand;
  logic               w_expire;

  // An all-zero seed would lock the LFSR up.
  assign w_seed = (LFSR_SEED == 16'h0000) ? LFSR_DEFAULT_SEED : LFSR_SEED;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (w_seed),
    .q     (w_lfsr)
  );

  // Bump to the next hole rather than repeat the current one.
  assign w_lfsr_pos = w_lfsr[POS_W-1:0];
  assign w_cand     = (w_lfsr_pos == r_pos) ? w_lfsr_pos + 3'd1 : w_lfsr_pos;
  assign w_expire   = (r_dwell_cnt == r_dwell - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HIDE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_gap_nx       = r_gap_cnt;
    w_dwell_cnt_nx = r_dwell_cnt;
    w_dwell_nx     = r_dwell;
    w_pos_nx       = r_pos;
    w_change_nx    = 1'b0;
    if (i_restart_game) begin
      w_state_nx     = ST_HIDE;
      w_gap_nx       = '0;
      w_dwell_cnt_nx = '0;
      w_pos_nx       = '0;
    end else if (i_game_over) begin
      w_state_nx = ST_OVER;
    end else begin
      case (r_state)
        ST_HIDE: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nx     = ST_SHOW;
            w_gap_nx       = '0;
            w_pos_nx       = w_cand;
            w_change_nx    = 1'b1;
            w_dwell_cnt_nx = '0;
            w_dwell_nx     = calc_dwell(i_score, DWELL_INIT, DWELL_MIN, DWELL_STEP);
          end else begin
            w_gap_nx = r_gap_cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          // A hit landing on the expiry cycle still yields a single return to HIDE.
          if (i_guess_correct || w_expire) begin
            w_state_nx = ST_HIDE;
            w_gap_nx   = '0;
          end else begin
            w_dwell_cnt_nx = r_dwell_cnt + CNT_W'(1);
          end
        end
        ST_OVER: w_state_nx = ST_OVER;
        default: w_state_nx = ST_HIDE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt   <= '0;
      r_dwell_cnt <= '0;
      r_dwell     <= CNT_W'(DWELL_INIT);
      r_pos       <= '0;
      r_change    <= 1'b0;
    end else begin
      r_gap_cnt   <= w_gap_nx;
      r_dwell_cnt <= w_dwell_cnt_nx;
      r_dwell     <= w_dwell_nx;
      r_pos       <= w_pos_nx;
      r_change    <= w_change_nx;
    end
  end

  assign mole_pos     = r_pos;
  assign mole_change  = r_change;
  assign mole_visible = (r_state == ST_SHOW);

endmodule

// File: tb/tb_mole_generator.sv
// Bench for mole_generator: expected mole arrival cycles and dwell lengths are
// queued by the stimulus and checked by a monitor as moles appear and vanish.
module tb_mole_generator;

  localparam int GAP = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       game_over = 1'b0;
  logic       guess = 1'b0;
  logic [7:0] score = 8'd0;
  logic [2:0] mole_pos;
  logic       mole_change;
  logic       mole_visible;

  always #5 clk = ~clk;

  mole_generator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_restart_game  (restart),
    .i_game_over     (game_over),
    .i_guess_correct (guess),
    .i_score         (score),
    .mole_pos        (mole_pos),
    .mole_change     (mole_change),
    .mole_visible    (mole_visible)
  );

  typedef struct { int cyc; int dwell; } exp_t;
  typedef struct { logic [7:0] score; int dwell; } vec_t;

  exp_t exp_q[$];
  vec_t vecs[4];
  int   checks = 0, errors = 0;
  int   cyc = 0, n_chg = 0, n_fall = 0;
  int   exp_c, c0;
  logic [2:0] p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_chg(input int n, input int max);
    int k = 0;
    while (n_chg < n && k < max) begin tick(); k++; end
    chk("wait_mole_change", int'(n_chg >= n), 1);
  endtask

  task automatic wait_fall(input int n, input int max);
    int k = 0;
    while (n_fall < n && k < max) begin tick(); k++; end
    chk("wait_mole_hide", int'(n_fall >= n), 1);
  endtask

  // Monitor: arrival cycle, pulse width, no-repeat and visible length per mole.
  logic       prev_chg = 1'b0, prev_vis = 1'b0;
  logic [2:0] prev_pos = 3'd0;
  int         vis_len = 0;
  exp_t       cur;
  bit         have_cur = 1'b0;

  always @(negedge clk) begin
    if (mole_change) begin
      n_chg++;
      chk("chg_width", int'(prev_chg), 0);
      chk("pos_no_repeat", int'(mole_pos != prev_pos), 1);
      chk("vis_at_chg", int'(mole_visible), 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        have_cur = 1'b0;
        $display("FAIL unexpected_mole cycle=%0d expected=none", cyc);
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
        chk("chg_cycle", cyc, cur.cyc);
      end
    end
    if (mole_visible) vis_len = prev_vis ? vis_len + 1 : 1;
    else if (prev_vis) begin
      n_fall++;
      if (have_cur && cur.dwell != 0) chk("dwell_len", vis_len, cur.dwell);
    end
    prev_chg = mole_change;
    prev_vis = mole_visible;
    prev_pos = mole_pos;
  end

  initial begin
    vecs = '{'{8'd0, 10000}, '{8'd10, 8000}, '{8'd40, 2000}, '{8'd255, 2000}};

    repeat (3) tick();
    chk("rst_pos", mole_pos, 0);
    chk("rst_chg", mole_change, 0);
    chk("rst_vis", mole_visible, 0);

    // Four back-to-back moles; next score is changed mid-SHOW and must
    // only take effect on the following mole.
    score = vecs[0].score;
    rst_n = 1'b1;
    exp_c = cyc + GAP;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{exp_c, vecs[i].dwell});
      exp_c += vecs[i].dwell + GAP;
    end
    for (int i = 0; i < 4; i++) begin
      wait_chg(i + 1, 16000);
      if (i < 3) score = vecs[i + 1].score;
    end
    wait_fall(4, 3000);

    // Hit pulse while hidden is ignored: next mole keeps its schedule.
    repeat (10) tick();
    guess = 1'b1;
    tick();
    guess = 1'b0;
    chk("hide_guess_vis", mole_visible, 0);
    exp_q.push_back('{exp_c, 0});
    wait_chg(5, 6000);

    // Hit 100 cycles into SHOW.
    repeat (100) tick();
    guess = 1'b1;
    c0 = cyc;
    tick();
    guess = 1'b0;
    chk("hit_vis", mole_visible, 0);
    exp_q.push_back('{c0 + 1 + GAP, 0});
    wait_chg(6, 6000);

    // Game over mid-SHOW, then released without restart: stays frozen.
    repeat (50) tick();
    p = mole_pos;
    game_over = 1'b1;
    tick();
    chk("over_vis", mole_visible, 0);
    chk("over_pos", mole_pos, p);
    chk("over_chg", mole_change, 0);
    repeat (20) tick();
    game_over = 1'b0;
    repeat (6000) tick();
    chk("over_hold_vis", mole_visible, 0);
    chk("over_no_mole", n_chg, 6);
    chk("over_pos_held", mole_pos, p);

    // Restart together with game over: restart wins.
    restart = 1'b1;
    game_over = 1'b1;
    tick();
    chk("restart_pos", mole_pos, 0);
    chk("restart_vis", mole_visible, 0);
    repeat (2) tick();
    chk("restart_held_vis", mole_visible, 0);
    restart = 1'b0;
    game_over = 1'b0;
    exp_q.push_back('{cyc + GAP, 2000});
    wait_chg(7, 6000);

    // Hit on the very cycle dwell expires: one return to HIDE.
    repeat (1999) tick();
    guess = 1'b1;
    c0 = cyc;
    tick();
    guess = 1'b0;
    chk("coinc_vis", mole_visible, 0);
    exp_q.push_back('{c0 + 1 + GAP, 0});
    wait_chg(8, 6000);

    // Async reset mid-SHOW, checked between clock edges.
    repeat (30) tick();
    chk("pre_arst_vis", mole_visible, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vis", mole_visible, 0);
    chk("arst_pos", mole_pos, 0);
    chk("arst_chg", mole_change, 0);
    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
